// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants for the booth_seq_mul multiplier
package booth_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Booth codes are {Q[0], q_1}
  localparam logic [1:0] BOOTH_SKIP_LO = 2'b00;
  localparam logic [1:0] BOOTH_ADD     = 2'b01;
  localparam logic [1:0] BOOTH_SUB     = 2'b10;
  localparam logic [1:0] BOOTH_SKIP_HI = 2'b11;

endpackage

// File: rtl/cla_16.sv
// rtl/cla_16.sv - 16-bit two-level carry-lookahead adder
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries are all expanded from cin so no stage waits on another
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/booth_seq_mul.sv
// rtl/booth_seq_mul.sv - sequential radix-2 Booth 16x16 signed multiplier
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int CNT_W_P = CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH_P-1:0]     multiplicand,
  input  logic [WIDTH_P-1:0]     multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH_P-1:0]   product
);

  logic [1:0]         state;
  logic [WIDTH_P-1:0] a;
  logic [WIDTH_P-1:0] q;
  logic               q_1;
  logic [WIDTH_P-1:0] m;
  logic [CNT_W_P-1:0] cnt;

  logic [1:0]         code;
  logic [WIDTH_P-1:0] op_b;
  logic               cin;
  logic [WIDTH_P-1:0] sum;
  logic               cout;
  logic [WIDTH_P-1:0] s;
  logic               t;

  assign code = {q[0], q_1};

  always_comb begin
    op_b = m;
    cin  = 1'b0;
    s    = a;
    t    = a[WIDTH_P-1];
    case (code)
      BOOTH_ADD: begin
        op_b = m;
        cin  = 1'b0;
        s    = sum;
        t    = a[WIDTH_P-1] ^ op_b[WIDTH_P-1] ^ cout;
      end
      BOOTH_SUB: begin
        op_b = ~m;
        cin  = 1'b1;
        s    = sum;
        t    = a[WIDTH_P-1] ^ op_b[WIDTH_P-1] ^ cout;
      end
      BOOTH_SKIP_LO, BOOTH_SKIP_HI: begin
        s = a;
        t = a[WIDTH_P-1];
      end
      default: begin
        s = a;
        t = a[WIDTH_P-1];
      end
    endcase
  end

  cla_16 u_cla (
    .a    (a),
    .b    (op_b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // t is the 17th bit of the exact sum, so shifting it in keeps M=-32768 exact
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            a     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a   <= {t, s[WIDTH_P-1:1]};
          q   <= {s[0], q[WIDTH_P-1:1]};
          q_1 <= q[0];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W_P'(WIDTH_P - 1)) begin
            product <= {t, s, q[WIDTH_P-1:1]};
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb/tb_booth_seq_mul.sv - self-checking bench for booth_seq_mul
module tb_booth_seq_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests_run;
  int tests_failed;
  int cyc;

  booth_seq_mul dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    longint px;
    longint py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 32'(px * py);
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1;
    multiplicand = x;
    multiplier = y;
    @(negedge clk);
    start = 1'b0;
    multiplicand = 16'($urandom);
    multiplier = 16'($urandom);
  endtask

  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = 16'h1234;
    multiplier = 16'h5678;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++;
    if (product !== 32'h0) begin tests_failed++; $display("FAIL reset_product got %h want 0", product); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bc;
    bit seen;
    issue(16'd3, 16'd5);
    wait_done(bc, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL basic_done got timeout want done"); end
    tests_run++;
    if (bc !== 16) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
    tests_run++;
    if (product !== model(16'd3, 16'd5)) begin
      tests_failed++; $display("FAIL basic_product got %h want %h", product, model(16'd3, 16'd5));
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b want 0", done); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (product !== 32'h0000000F) begin tests_failed++; $display("FAIL basic_hold got %h want 0000000f", product); end
  endtask

  task automatic test_directed();
    logic [15:0] xs [6];
    logic [15:0] ys [6];
    int bc;
    bit seen;
    xs = '{16'hFFF9, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF};
    ys = '{16'h0006, 16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 6; i++) begin
      issue(xs[i], ys[i]);
      wait_done(bc, seen);
      tests_run++;
      if (!seen || product !== model(xs[i], ys[i])) begin
        tests_failed++;
        $display("FAIL directed_%0d %h*%h got %h done=%b want %h", i, xs[i], ys[i], product, seen, model(xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    int bc;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      issue(x, y);
      wait_done(bc, seen);
      tests_run++;
      if (!seen || bc !== 16 || product !== model(x, y)) begin
        tests_failed++;
        $display("FAIL random_%0d %h*%h got %h busy=%0d done=%b want %h", i, x, y, product, bc, seen, model(x, y));
      end
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [31:0] got;
    pulses = 0;
    got = '0;
    issue(16'd100, 16'd200);
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        pulses++;
        got = product;
      end
      // start is held high through the DONE cycle too; DONE must ignore it
      start = ((i >= 3 && i <= 10) || done) ? 1'b1 : 1'b0;
      multiplicand = 16'($urandom);
      multiplier = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    tests_run++;
    if (got !== 32'h00004E20) begin tests_failed++; $display("FAIL ignore_product got %h want 00004e20", got); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int bc;
    bit seen;
    logic [15:0] y;
    y = 16'hE9D2;
    issue(16'd1234, y);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_state got busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL midreset_no_done got %0d pulses want 0", pulses); end
    issue(16'd1234, y);
    wait_done(bc, seen);
    tests_run++;
    if (!seen || product !== model(16'd1234, y)) begin
      tests_failed++; $display("FAIL midreset_restart got %h want %h", product, model(16'd1234, y));
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit seen;
    int t1;
    int t2;
    issue(16'd2, 16'd3);
    wait_done(bc, seen);
    t1 = cyc;
    tests_run++;
    if (!seen || product !== 32'd6) begin tests_failed++; $display("FAIL b2b_first got %h want 00000006", product); end
    @(negedge clk);
    start = 1'b1;
    multiplicand = 16'hFFFC;
    multiplier = 16'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, seen);
    t2 = cyc;
    tests_run++;
    if (!seen || product !== model(16'hFFFC, 16'd4)) begin
      tests_failed++; $display("FAIL b2b_second got %h want %h", product, model(16'hFFFC, 16'd4));
    end
    tests_run++;
    if (t2 - t1 !== 18) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 18", t2 - t1); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
